// File: rtl/counter_pkg.sv
// Shared encodings for the step counter: bound behaviour and count direction.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/step_sync.sv
// Synchronises an asynchronous step request and turns each rising edge into
// a single-cycle pulse.
module step_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d  = sync_q[SYNC_STAGES-1];
        // Pulse is decoded straight from flops so the step lands one edge after the last stage.
        pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Up/down step counter with configurable upper bound, wrap or saturate at the
// bounds, and a one-cycle terminal-count pulse on bound-hitting steps.
module step_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MAX         = 2**WIDTH - 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic             dir_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    logic             step_pulse;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    step_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(step_i),
        .pulse_o(step_pulse)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = (load_val_i > MAX_C) ? MAX_C : load_val_i;
        end else if (step_pulse && en_i) begin
            // Bounds are MAX and 0, so wrap arithmetic is modulo MAX+1.
            if (dir_i == DIR_UP) begin
                if (count_q >= MAX_C) begin
                    tc_d    = 1'b1;
                    count_d = (mode_i == MODE_SAT) ? MAX_C : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (mode_i == MODE_SAT) ? '0 : MAX_C;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o  = count_q;
    assign tc_o     = tc_q;
    assign at_max_o = (count_q == MAX_C);
    assign at_min_o = (count_q == '0);

endmodule

// File: tb/tb_step_counter.sv
// Directed testbench for step_counter: three instances cover MAX=15, MAX=9
// and a three-stage synchroniser, all driven from shared inputs.
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_i = 1'b0;
    logic       dir_i = 1'b1;
    logic       en_i = 1'b1;
    logic       mode_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] load_val_i = 4'd0;

    logic [3:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;
    logic       max_a, max_b, max_c;
    logic       min_a, min_b, min_c;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    step_counter #(.WIDTH(4), .MAX(15), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .dir_i(dir_i), .en_i(en_i),
        .mode_i(mode_i), .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_o(count_a), .tc_o(tc_a), .at_max_o(max_a), .at_min_o(min_a)
    );

    step_counter #(.WIDTH(4), .MAX(9), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .dir_i(dir_i), .en_i(en_i),
        .mode_i(mode_i), .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_o(count_b), .tc_o(tc_b), .at_max_o(max_b), .at_min_o(min_b)
    );

    step_counter #(.WIDTH(4), .MAX(15), .SYNC_STAGES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .dir_i(dir_i), .en_i(en_i),
        .mode_i(mode_i), .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_o(count_c), .tc_o(tc_c), .at_max_o(max_c), .at_min_o(min_c)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle step_i pulse; returns after the edge where a 2-stage DUT updates.
    task automatic pulse_step(input int unsigned extra);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick();
        tick();
        repeat (extra) tick();
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        load_val_i = v;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++; if (count_a !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_a); end
        n_vec++; if (tc_a !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b exp=0", tc_a); end
        n_vec++; if (min_a !== 1'b1) begin n_err++; $display("FAIL reset_at_min got=%b exp=1", min_a); end
        n_vec++; if (max_a !== 1'b0) begin n_err++; $display("FAIL reset_at_max got=%b exp=0", max_a); end
        n_vec++; if (count_c !== 4'd0) begin n_err++; $display("FAIL reset_count_c got=%0d exp=0", count_c); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_cnt;
        mode_i = 1'b0;
        dir_i  = 1'b1;
        do_clear();
        for (int i = 1; i <= 17; i++) begin
            pulse_step(0);
            exp_cnt = (i == 16) ? 4'd0 : (i == 17) ? 4'd1 : 4'(i);
            n_vec++; if (count_a !== exp_cnt) begin n_err++; $display("FAIL wrap_up_count step=%0d got=%0d exp=%0d", i, count_a, exp_cnt); end
            n_vec++; if (tc_a !== (i == 16)) begin n_err++; $display("FAIL wrap_up_tc step=%0d got=%b exp=%b", i, tc_a, (i == 16)); end
            if (i == 16) begin
                tick();
                n_vec++; if (tc_a !== 1'b0) begin n_err++; $display("FAIL wrap_up_tc_width got=%b exp=0", tc_a); end
            end
        end
    endtask

    task automatic test_sat_up();
        mode_i = 1'b1;
        dir_i  = 1'b1;
        do_clear();
        for (int i = 1; i <= 12; i++) begin
            pulse_step(0);
            n_vec++; if (count_b !== ((i > 9) ? 4'd9 : 4'(i))) begin n_err++; $display("FAIL sat_up_count step=%0d got=%0d exp=%0d", i, count_b, (i > 9) ? 9 : i); end
            n_vec++; if (tc_b !== (i >= 10)) begin n_err++; $display("FAIL sat_up_tc step=%0d got=%b exp=%b", i, tc_b, (i >= 10)); end
            n_vec++; if (max_b !== (i >= 9)) begin n_err++; $display("FAIL sat_up_at_max step=%0d got=%b exp=%b", i, max_b, (i >= 9)); end
        end
        tick();
        n_vec++; if (tc_b !== 1'b0) begin n_err++; $display("FAIL sat_up_tc_low got=%b exp=0", tc_b); end
    endtask

    task automatic test_wrap_down_and_load();
        mode_i = 1'b0;
        dir_i  = 1'b0;
        do_clear();
        pulse_step(0);
        n_vec++; if (count_b !== 4'd9) begin n_err++; $display("FAIL wrap_down_count got=%0d exp=9", count_b); end
        n_vec++; if (tc_b !== 1'b1) begin n_err++; $display("FAIL wrap_down_tc got=%b exp=1", tc_b); end
        pulse_step(0);
        n_vec++; if (count_b !== 4'd8) begin n_err++; $display("FAIL down_step_count got=%0d exp=8", count_b); end
        do_load(4'd14);
        n_vec++; if (count_b !== 4'd9) begin n_err++; $display("FAIL load_clamp_count got=%0d exp=9", count_b); end
        n_vec++; if (tc_b !== 1'b0) begin n_err++; $display("FAIL load_clamp_tc got=%b exp=0", tc_b); end
        n_vec++; if (count_a !== 4'd14) begin n_err++; $display("FAIL load_a_count got=%0d exp=14", count_a); end
        dir_i = 1'b1;
        pulse_step(0);
        n_vec++; if (count_b !== 4'd0) begin n_err++; $display("FAIL wrap_mod_max_count got=%0d exp=0", count_b); end
        n_vec++; if (tc_b !== 1'b1) begin n_err++; $display("FAIL wrap_mod_max_tc got=%b exp=1", tc_b); end
        n_vec++; if (count_a !== 4'd15) begin n_err++; $display("FAIL wrap_a_inc got=%0d exp=15", count_a); end
        do_load(4'd5);
        n_vec++; if (count_b !== 4'd5) begin n_err++; $display("FAIL load_plain_count got=%0d exp=5", count_b); end
    endtask

    task automatic test_latency();
        mode_i = 1'b0;
        dir_i  = 1'b1;
        do_clear();
        tick();
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick();
        n_vec++; if (count_c !== 4'd0) begin n_err++; $display("FAIL latency_k1 got=%0d exp=0", count_c); end
        tick();
        n_vec++; if (count_c !== 4'd0) begin n_err++; $display("FAIL latency_k2 got=%0d exp=0", count_c); end
        tick();
        n_vec++; if (count_c !== 4'd1) begin n_err++; $display("FAIL latency_k3 got=%0d exp=1", count_c); end
        step_i = 1'b1;
        repeat (20) tick();
        step_i = 1'b0;
        repeat (5) tick();
        n_vec++; if (count_c !== 4'd2) begin n_err++; $display("FAIL held_high_count got=%0d exp=2", count_c); end
        n_vec++; if (count_a !== 4'd2) begin n_err++; $display("FAIL held_high_count_a got=%0d exp=2", count_a); end
    endtask

    task automatic test_collisions();
        mode_i = 1'b0;
        dir_i  = 1'b1;
        do_load(4'd15);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        n_vec++; if (count_a !== 4'd0) begin n_err++; $display("FAIL clr_collide_count got=%0d exp=0", count_a); end
        n_vec++; if (tc_a !== 1'b0) begin n_err++; $display("FAIL clr_collide_tc got=%b exp=0", tc_a); end
        repeat (3) tick();
        n_vec++; if (count_a !== 4'd0) begin n_err++; $display("FAIL clr_collide_later got=%0d exp=0", count_a); end
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick();
        do_load(4'd6);
        n_vec++; if (count_a !== 4'd6) begin n_err++; $display("FAIL load_collide_count got=%0d exp=6", count_a); end
        repeat (3) tick();
        n_vec++; if (count_a !== 4'd6) begin n_err++; $display("FAIL load_collide_later got=%0d exp=6", count_a); end
        en_i = 1'b0;
        pulse_step(1);
        en_i = 1'b1;
        repeat (3) tick();
        n_vec++; if (count_a !== 4'd6) begin n_err++; $display("FAIL en_low_count got=%0d exp=6", count_a); end
        n_vec++; if (tc_a !== 1'b0) begin n_err++; $display("FAIL en_low_tc got=%b exp=0", tc_a); end
    endtask

    task automatic test_reset_midflight();
        dir_i = 1'b1;
        do_load(4'd7);
        n_vec++; if (count_a !== 4'd7) begin n_err++; $display("FAIL midflight_preload got=%0d exp=7", count_a); end
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (count_a !== 4'd0) begin n_err++; $display("FAIL midflight_async_count got=%0d exp=0", count_a); end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_vec++; if (count_a !== 4'd0) begin n_err++; $display("FAIL midflight_lost_step got=%0d exp=0", count_a); end
        rst_n = 1'b0;
        step_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_vec++; if (count_a !== 4'd1) begin n_err++; $display("FAIL high_after_reset got=%0d exp=1", count_a); end
        repeat (4) tick();
        n_vec++; if (count_a !== 4'd1) begin n_err++; $display("FAIL high_after_reset_once got=%0d exp=1", count_a); end
        step_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_up();
        test_wrap_down_and_load();
        test_latency();
        test_collisions();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
